// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV64 data-memory responder with wait states; optional DMEM_MISALIGN_CHECK_EN
module dmem_responder #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int idxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
    stateT state, stateNext;

    // Request captured at the accept edge
    logic              weQ;
    logic [2:0]        typeQ;
    logic [63:0]       addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [3:0]        cntQ;

    logic [DATA_W-1:0] rdataQ;
    logic              errQ;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Access-side view of the request: live inputs in IDLE (zero-wait case), latched copy otherwise
    logic              accWe;
    logic [2:0]        accType;
    logic [63:0]       accAddr;
    logic [DATA_W-1:0] accWdata;
    logic [idxW-1:0]   accIdx;
    logic [2:0]        accOff;
    logic [3:0]        accSize;
    logic              rangeErr, alignErr, accErr, doAccess;
    logic [DATA_W-1:0] curWord, newWord, rawData, loadData;
    logic [2:0]        lane;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdataQ;
    assign resp_err   = errQ;

    // Select live request fields while idle, latched fields afterwards
    always_comb begin
        accWe    = weQ;
        accType  = typeQ;
        accAddr  = addrQ;
        accWdata = wdataQ;
        if (state == IDLE) begin
            accWe    = req_we;
            accType  = req_type;
            accAddr  = req_addr;
            accWdata = req_wdata;
        end
    end

    assign accIdx   = accAddr[3 +: idxW];
    assign accOff   = accAddr[2:0];
    assign accSize  = 4'd1 << accType[1:0];
    assign rangeErr = |accAddr[63:3+idxW];
    assign curWord  = mem[accIdx];

`ifdef DMEM_MISALIGN_CHECK_EN
    // Natural-alignment check on halfword, word and doubleword accesses
    always_comb begin
        alignErr = 1'b0;
        case (accType[1:0])
            2'b01:   alignErr = accOff[0];
            2'b10:   alignErr = |accOff[1:0];
            2'b11:   alignErr = |accOff;
            default: alignErr = 1'b0;
        endcase
    end
`else
    assign alignErr = 1'b0;
`endif

    assign accErr = (accType == 3'b111) || rangeErr || alignErr;

    // The access fires at the accept edge when there are no wait states, else when the countdown expires
    assign doAccess = reset &&
                      (((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cntQ == 4'd0)));

    // Gather load bytes and merge store bytes; lanes wrap modulo 8 inside the word
    always_comb begin
        rawData = '0;
        newWord = curWord;
        lane    = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < accSize) begin
                lane = accOff + 3'(k);
                rawData[8*k +: 8]           = curWord[{lane, 3'b000} +: 8];
                newWord[{lane, 3'b000} +: 8] = accWdata[8*k +: 8];
            end
        end
    end

    // Sign-extend B/H/W; unsigned variants are already zero-filled, D is the full word
    always_comb begin
        loadData = rawData;
        if (!accType[2]) begin
            case (accType[1:0])
                2'b00:   loadData = {{56{rawData[7]}},  rawData[7:0]};
                2'b01:   loadData = {{48{rawData[15]}}, rawData[15:0]};
                2'b10:   loadData = {{32{rawData[31]}}, rawData[31:0]};
                default: loadData = rawData;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req_valid) stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cntQ == 4'd0) stateNext = RESP;
            RESP:    if (resp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weQ    <= 1'b0;
            typeQ  <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            cntQ   <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                weQ    <= req_we;
                typeQ  <= req_type;
                addrQ  <= req_addr;
                wdataQ <= req_wdata;
                cntQ   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
            end else if ((state == WAIT) && (cntQ != 4'd0)) begin
                cntQ <= cntQ - 4'd1;
            end
            if (doAccess) begin
                rdataQ <= (accErr || accWe) ? '0 : loadData;
                errQ   <= accErr;
            end else if ((state == RESP) && resp_ready) begin
                rdataQ <= '0;
                errQ   <= 1'b0;
            end
        end
    end

    // Word array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (doAccess && accWe && !accErr) mem[accIdx] <= newWord;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (vectors, corner sequences, random vs model)
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rv [2], rr [2], we [2], sv [2], sr [2], er [2];
    logic [2:0]  ty [2];
    logic [63:0] ad [2], wd [2], rd [2];

    int passCnt = 0;
    int totalCnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DATA_W(64), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(we[0]),
        .req_type(ty[0]), .req_addr(ad[0]), .req_wdata(wd[0]), .resp_valid(sv[0]),
        .resp_ready(sr[0]), .resp_rdata(rd[0]), .resp_err(er[0]));

    dmem_responder #(.DATA_W(64), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(we[1]),
        .req_type(ty[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .resp_valid(sv[1]),
        .resp_ready(sr[1]), .resp_rdata(rd[1]), .resp_err(er[1]));

    // Byte-addressed reference memory per DUT
    bit [7:0] mb [2][8*DEPTH];

    typedef struct {
        bit        w;
        bit [2:0]  t;
        bit [63:0] a;
        bit [63:0] wdat;
        bit [63:0] expR;
        bit        expE;
    } vecT;
    vecT vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    function automatic void model(input int d, input bit w, input bit [2:0] t, input bit [63:0] a,
                                  input bit [63:0] wdat, output bit [63:0] r, output bit e);
        int size;
        int base;
        int off;
        size = 1 << t[1:0];
        r = '0;
        e = (t == 3'd7) || (a >= 64'(8 * DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((a % 64'(size)) != 64'd0) e = 1'b1;
`endif
        if (e) return;
        base = int'(a) & ~7;
        off  = int'(a) & 7;
        for (int k = 0; k < size; k++) begin
            int ba;
            ba = base + (off + k) % 8;
            if (w) mb[d][ba] = wdat[8*k +: 8];
            else   r[8*k +: 8] = mb[d][ba];
        end
        if (!w && !t[2] && size < 8 && r[8*size-1]) r = r | ~((64'd1 << (8 * size)) - 64'd1);
    endfunction

    // One full transaction; entered and left on a falling edge
    task automatic xact(input int d, input bit w, input bit [2:0] t, input bit [63:0] a, input bit [63:0] wdat,
                        output logic [63:0] r, output logic e, output int lat, output int acc);
        int n;
        rv[d] = 1'b1; we[d] = w; ty[d] = t; ad[d] = a; wd[d] = wdat;
        n = 0;
        while (rr[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("req_ready_seen", 64'(rr[d]), 64'd1);
        @(negedge clk);
        acc = cyc;
        rv[d] = 1'b0;
        we[d] = 1'($urandom); ty[d] = 3'($urandom); ad[d] = {$urandom, $urandom}; wd[d] = {$urandom, $urandom};
        lat = 0;
        while (sv[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        check("resp_valid_seen", 64'(sv[d]), 64'd1);
        r = rd[d];
        e = er[d];
        sr[d] = 1'b1;
        @(negedge clk);
        sr[d] = 1'b0;
    endtask

    function automatic void addVec(input bit w, input bit [2:0] t, input bit [63:0] a, input bit [63:0] wdat,
                                   input bit [63:0] expR, input bit expE);
        vecT v;
        v.w = w; v.t = t; v.a = a; v.wdat = wdat; v.expR = expR; v.expE = expE;
        vecs.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit 1000000 reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] r, r2;
        logic        e;
        bit   [63:0] mr, mr2;
        bit          me;
        int          lat, acc, prevAcc, n;

        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; we[d] = 0; ty[d] = 0; ad[d] = 0; wd[d] = 0; sr[d] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(rr[0]), 64'd1);
        check("rst_resp_valid", 64'(sv[0]), 64'd0);
        check("rst_rdata", rd[0], 64'd0);
        check("rst_err", 64'(er[0]), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            mr2 = {$urandom, $urandom};
            model(0, 1'b1, 3'b011, 64'(8 * i), mr2, mr, me);
            xact(0, 1'b1, 3'b011, 64'(8 * i), mr2, r, e, lat, acc);
        end

        addVec(1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0);
        addVec(0, 3'b011, 64'h10, 64'h0, 64'h1122334455667788, 0);
        addVec(1, 3'b000, 64'h13, 64'h80, 64'h0, 0);
        addVec(0, 3'b000, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
        addVec(0, 3'b100, 64'h13, 64'h0, 64'h80, 0);
        addVec(0, 3'b011, 64'h10, 64'h0, 64'h1122334480667788, 0);
        addVec(1, 3'b011, 64'h10, 64'h8000000011112222, 64'h0, 0);
        addVec(0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF80000000, 0);
        addVec(0, 3'b110, 64'h14, 64'h0, 64'h0000000080000000, 0);
        addVec(0, 3'b011, 64'(8 * DEPTH), 64'h0, 64'h0, 1);
        addVec(1, 3'b111, 64'h10, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1);
        addVec(0, 3'b011, 64'h10, 64'h0, 64'h8000000011112222, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        addVec(0, 3'b001, 64'h11, 64'h0, 64'h0, 1);
        addVec(1, 3'b001, 64'h17, 64'hAABB, 64'h0, 1);
        addVec(0, 3'b011, 64'h10, 64'h0, 64'h8000000011112222, 0);
`else
        addVec(1, 3'b001, 64'h17, 64'hAABB, 64'h0, 0);
        addVec(0, 3'b011, 64'h10, 64'h0, 64'hBB000000111122AA, 0);
        addVec(0, 3'b101, 64'h16, 64'h0, 64'hBB00, 0);
        addVec(0, 3'b001, 64'h17, 64'h0, 64'hFFFFFFFFFFFFAABB, 0);
`endif
        addVec(1, 3'b011, 64'(8 * DEPTH + 8), 64'h1234, 64'h0, 1);
        addVec(0, 3'b000, 64'h8000000000000010, 64'h0, 64'h0, 1);

        prevAcc = 0;
        foreach (vecs[i]) begin
            model(0, vecs[i].w, vecs[i].t, vecs[i].a, vecs[i].wdat, mr, me);
            xact(0, vecs[i].w, vecs[i].t, vecs[i].a, vecs[i].wdat, r, e, lat, acc);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].expR);
            check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].expE));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
            if (i > 0) check($sformatf("vec%0d_throughput", i), 64'(acc - prevAcc), 64'd3);
            prevAcc = acc;
        end

        // Backpressure: response held, second request waits for the handshake
        model(0, 1'b0, 3'b011, 64'h10, 64'h0, mr, me);
        model(0, 1'b0, 3'b011, 64'h18, 64'h0, mr2, me);
        rv[0] = 1; we[0] = 0; ty[0] = 3'b011; ad[0] = 64'h10;
        @(negedge clk);
        ad[0] = 64'h18;
        n = 0;
        while (sv[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_resp_valid", k), 64'(sv[0]), 64'd1);
            check($sformatf("bp%0d_rdata", k), rd[0], mr);
            check($sformatf("bp%0d_req_ready", k), 64'(rr[0]), 64'd0);
            @(negedge clk);
        end
        sr[0] = 1;
        @(negedge clk);
        sr[0] = 0;
        check("bp_after_hs_valid", 64'(sv[0]), 64'd0);
        check("bp_after_hs_ready", 64'(rr[0]), 64'd1);
        @(negedge clk);
        rv[0] = 0;
        check("bp_second_accepted", 64'(rr[0]), 64'd0);
        n = 0;
        while (sv[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("bp_second_rdata", rd[0], mr2);
        sr[0] = 1;
        @(negedge clk);
        sr[0] = 0;

        // Reset during WAIT of a store: store must be dropped
        model(0, 1'b0, 3'b011, 64'h20, 64'h0, mr, me);
        rv[0] = 1; we[0] = 1; ty[0] = 3'b011; ad[0] = 64'h20; wd[0] = 64'hDEAD;
        @(negedge clk);
        rv[0] = 0;
        check("wait_req_ready", 64'(rr[0]), 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 64'(rr[0]), 64'd1);
        check("midrst_resp_valid", 64'(sv[0]), 64'd0);
        check("midrst_rdata", rd[0], 64'd0);
        check("midrst_err", 64'(er[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        xact(0, 1'b0, 3'b011, 64'h20, 64'h0, r, e, lat, acc);
        check("midrst_prior_kept", r, mr);

        // Reset after the store was performed: store must persist
        rv[0] = 1; we[0] = 1; ty[0] = 3'b011; ad[0] = 64'h28; wd[0] = 64'hBEEF;
        @(negedge clk);
        rv[0] = 0;
        n = 0;
        while (sv[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        model(0, 1'b1, 3'b011, 64'h28, 64'hBEEF, mr, me);
        reset = 1'b0;
        #1;
        check("resprst_resp_valid", 64'(sv[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        xact(0, 1'b0, 3'b011, 64'h28, 64'h0, r, e, lat, acc);
        check("resprst_store_kept", r, 64'hBEEF);

        // Three wait states: latency and throughput
        model(1, 1'b1, 3'b011, 64'h40, 64'h0123456789ABCDEF, mr, me);
        xact(1, 1'b1, 3'b011, 64'h40, 64'h0123456789ABCDEF, r, e, lat, prevAcc);
        check("w3_store_latency", 64'(lat), 64'd3);
        check("w3_store_err", 64'(e), 64'd0);
        xact(1, 1'b0, 3'b011, 64'h40, 64'h0, r, e, lat, acc);
        check("w3_load_latency", 64'(lat), 64'd3);
        check("w3_load_rdata", r, 64'h0123456789ABCDEF);
        check("w3_throughput", 64'(acc - prevAcc), 64'd5);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            bit        w;
            bit [2:0]  t;
            bit [63:0] a, wdat;
            w = 1'($urandom);
            t = 3'($urandom);
            wdat = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) a = 64'(8 * DEPTH) + 64'($urandom_range(0, 4095));
            else a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            model(0, w, t, a, wdat, mr, me);
            xact(0, w, t, a, wdat, r, e, lat, acc);
            check($sformatf("rnd%0d_rdata", i), r, mr);
            check($sformatf("rnd%0d_err", i), 64'(e), 64'(me));
        end

        r2 = r;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the diag-v2 core's load/store port. Accepts one request at a time through a valid/ready handshake, performs the RV64 byte/half/word/double access with sign/zero extension and byte-lane stores into an internal word array, then presents the result through a second valid/ready handshake. It sits where the single-cycle data memory sits today and lets the core be exercised against memory with configurable wait states.

## Interface
Parameters:
- `DATA_W`, 64: data bus width; fixed at 64, with 8 byte lanes.
- `DEPTH_WORDS`, 1024: number of 64-bit words; power of two.
- `WAIT_CYCLES`, 1: extra cycles between accept and access; 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; equals (state==IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_type`  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 invalid.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  access rejected; no memory change.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch we/type/addr/wdata.
  - If `WAIT_CYCLES`=0: perform the access at the same edge and go to RESP.
  - Else: load the counter with `WAIT_CYCLES`-1 and go to WAIT.
- WAIT: the counter decrements each cycle. At the edge where the counter==0, perform the access and go to RESP.
- RESP: `resp_valid`=1, and `resp_rdata`/`resp_err` are held stable. On `resp_ready`, go to IDLE.
- Address decode:
  - Word index = addr[3+log2(DEPTH_WORDS)-1:3].
  - Lane offset = addr[2:0].
  - Any set bit above the index is out of range: resp_err=1.
- Store:
  - Size comes from type[1:0]; type[2] is ignored unless type==111.
  - Bytes of wdata[size-1:0] are written to lanes offset..offset+size-1 of the indexed word; other lanes are untouched.
- Load:
  - Bytes are gathered from the same lanes.
  - Sign-extended for types 000/001/010; zero-extended for 100/101/110; 011 returns the full word.
- Error cases: type 111, or out of range. The response is resp_err=1, resp_rdata=0, and no write.
- The array contents are not reset.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- Latency: with accept at edge N, the access happens at edge N+WAIT_CYCLES and `resp_valid` is high from edge N+WAIT_CYCLES.
- Throughput: one transaction per WAIT_CYCLES+2 cycles, given `resp_ready` held high.
- `req_ready` is 0 in WAIT and RESP; requests presented then are not accepted and must be held by the initiator.
- Back-to-back: the RESP→IDLE edge does not accept a request; acceptance happens in the following IDLE cycle.
- `resp_ready` outside RESP is ignored.
- Reset asserted mid-transaction:
  - Immediately returns to IDLE and clears outputs.
  - A store still in WAIT is never written.
  - A store already performed stays written.
- `req_*` inputs are sampled only at the accept edge; later changes have no effect.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined: the following are errors (resp_err=1, rdata 0, no write):
  - H/HU with addr[0]≠0.
  - W/WU with addr[1:0]≠0.
  - D with addr[2:0]≠0.
- Undefined: no misalignment error. Lanes wrap modulo 8 within the same word: lane = (addr[2:0]+k) mod 8. Range and type checks still apply.

## Test plan
- WAIT_CYCLES=1: store D 0x1122334455667788 at 0x10, then load D at 0x10 → rdata 0x1122334455667788, err 0; resp_valid is 1 cycle after the accept edge.
- Store B 0x80 at 0x13, then load B at 0x13 → 0xFFFFFFFFFFFFFF80; load BU → 0x80; load D at 0x10 → 0x1122334480667788.
- Load W at 0x14 of word 0x8000000011112222 → 0xFFFFFFFF80000000; WU → 0x0000000080000000.
- Error cases:
  - Out-of-range load at addr 8*DEPTH_WORDS → err 1, rdata 0.
  - Store with type 111 → err 1, memory unchanged.
  - With the macro, load H at 0x11 → err 1.
  - Without the macro, store H 0xAABB at 0x17 → lane 7=0xBB and lane 0=0xAA of word 2.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid stays 1 with rdata stable, req_ready stays 0, and a second request is accepted only after the response handshake. WAIT_CYCLES=3 → latency 3.
- Assert reset in WAIT during store D 0xDEAD at 0x20 → outputs return to reset values immediately, and a subsequent load at 0x20 returns the prior contents.
